gecko_fetch_queue: RTL and testbench
====================================

Name: gecko_fetch_queue

Overview:
- Sits directly downstream of the fetch stage.
- Pairs each issued fetch command (pc, next_pc, jump_flag, prediction) with its in-order instruction-memory response word.
- Discards work made stale by a redirect: any entry whose jump_flag differs from the expected flag is dropped.
- Presents a single registered, backpressured instruction stream to decode.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, >=2; must cover memory read latency.
- JUMP_FLAG_WIDTH, 2: width of jump_flag; expected flag wraps modulo 2**JUMP_FLAG_WIDTH.
- START_FLAG, 0: reset value of the expected jump flag; must equal the fetch stage's reset flag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  fetch command valid.
- cmd_ready  out  1  command accepted when high.
- cmd_pc  in  32  fetched pc.
- cmd_next_pc  in  32  predicted next pc.
- cmd_jump_flag  in  JUMP_FLAG_WIDTH  flag at issue.
- cmd_pred_miss  in  1  predictor table miss.
- cmd_pred_history  in  2  predictor history.
- rsp_valid  in  1  memory read data valid.
- rsp_ready  out  1  response accepted when high.
- rsp_data  in  32  instruction word.
- jump_valid  in  1  jump command from execute.
- jump_update_pc  in  1  jump redirected pc.
- out_valid  out  1  instruction valid.
- out_ready  in  1  decode accepts.
- out_pc, out_next_pc  out  32 each  pass-through.
- out_jump_flag  out  JUMP_FLAG_WIDTH  pass-through.
- out_pred_miss  out  1  pass-through.
- out_pred_history  out  2  pass-through.
- out_instruction  out  32  paired rsp_data.
- drop_count  out  32  stale entries discarded (see Optional Feature).

Behaviour:
- Reset state:
  - FIFO empty; count=0.
  - expected_flag=START_FLAG.
  - out_valid=0; all out_* payload =0.
  - cmd_ready=1 once rst deasserts.
  - rsp_ready=0; drop_count=0.
- Command accept: cmd_ready = count!=DEPTH.
  - Push on cmd_valid&&cmd_ready.
  - No full-bypass: a pop in the same cycle does not raise cmd_ready.
- Head visibility: a pushed entry becomes head the cycle after push. A response therefore cannot pair with a command pushed the same cycle; memory latency is >=1.
- Output slot: a single register; "free" = !out_valid || out_ready.
- Head stale: stale = head.jump_flag != expected_flag, evaluated with the post-update flag (see redirect).
- rsp_ready = count!=0 && (stale || free).
- Pair: on rsp_valid && rsp_ready, pop head.
  - If stale: drop both, no output, drop_count++.
  - Else: load the output register with head fields + rsp_data; out_valid=1 next cycle.
- Latency: response accepted cycle N -> out_valid at N+1.
- Output hold: out_* stable while out_valid && !out_ready.
- Redirect: jump_valid && jump_update_pc increments expected_flag (wrapping) at the clock edge. Combinational stale checks that cycle use the incremented value. The same cycle, the output register is cleared (out_valid=0) if its flag != the incremented value, regardless of out_ready.
- Simultaneous events, all legal in the same cycle, with independent pointers:
  - push + pop;
  - redirect + pair;
  - redirect + out handshake.
  - A redirect beats a pair: an entry paired in the redirect cycle is judged stale against the new flag.
- Protocol error: rsp_valid with count==0 is illegal; the response is ignored (rsp_ready=0). A simulation assertion fires.
- Reset mid-operation: everything returns asynchronously to reset values; in-flight responses after reset are the environment's problem.

Optional Feature:
- Macro: GECKO_FETCH_QUEUE_STATS_EN.
- Defined: drop_count is a 32-bit saturating counter (holds at 0xFFFFFFFF) of stale entries dropped, in both the pairing and output-register flush paths.
- Undefined: no counter logic; drop_count tied to 0.

Decomposition:
- Into gecko_pkg:
  - gecko_fetch_queue_entry_t (pc, next_pc, jump_flag, prediction.miss, prediction.history);
  - reuse gecko_jump_flag_t and gecko_prediction_history_t.
- Sub-module: gecko_fetch_queue_storage, a DEPTH-entry register FIFO with read/write pointers, count, full/empty and no bypass.
- Top level holds pairing, staleness, output register and counter.

Test Plan:
- In-order flow:
  - stimulus: push pc 0x0,0x4,0x8 (flag 0); responses 0x13,0x00100093,0x00200113 one cycle later each; out_ready=1.
  - response: outputs in order, each one cycle after its response, instructions matching.
- Full:
  - stimulus: push 4 commands with no responses.
  - response: cmd_ready=0 on cycle 5; stays 0 during a same-cycle pop; returns 1 next cycle.
- Redirect flush:
  - stimulus: 3 flag-0 commands queued; jump (update_pc=1); then responses, then pc 0x100 with flag 1.
  - response: 3 drops, drop_count=3 (macro on); only 0x100 is output.
- Redirect vs held output:
  - stimulus: out_valid=1 with flag 0, out_ready=0; jump pulse.
  - response: out_valid=0 next cycle.
- Backpressure: out_ready=0 for 5 cycles with 2 queued responses.
  - response: rsp_ready=0; payload stable; drains at 1 per cycle afterwards.
- Wrap and reset:
  - stimulus: 4 jumps.
  - response: expected_flag 0->1->2->3->0 and flag-0 entries accepted again.
  - stimulus: assert rst mid-stream.
  - response: out_valid=0 immediately, count=0.

Source files
------------

// File: rtl/gecko_pkg.sv
// Shared types for the gecko front end: jump flags, predictor state and the
// fetch-queue entry that travels with each outstanding instruction fetch.
package gecko_pkg;

    localparam int GECKO_XLEN            = 32;
    localparam int GECKO_JUMP_FLAG_WIDTH = 2;

    typedef logic [GECKO_JUMP_FLAG_WIDTH-1:0] gecko_jump_flag_t;
    typedef logic [1:0]                       gecko_prediction_history_t;

    typedef struct packed {
        logic                      miss;
        gecko_prediction_history_t history;
    } gecko_prediction_t;

    typedef struct packed {
        logic [GECKO_XLEN-1:0] pc;
        logic [GECKO_XLEN-1:0] next_pc;
        gecko_jump_flag_t      jump_flag;
        gecko_prediction_t     prediction;
    } gecko_fetch_queue_entry_t;

    // Adds a small increment to a 32-bit event counter, sticking at all-ones.
    function automatic logic [31:0] gecko_sat_add(input logic [31:0] value, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, value} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/gecko_fetch_queue_storage.sv
// DEPTH-entry register FIFO of fetch commands. No bypass: a pushed entry is
// visible at the head only from the cycle after the push.
module gecko_fetch_queue_storage
    import gecko_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  gecko_fetch_queue_entry_t wr_entry,
    input  logic                     pop,
    output gecko_fetch_queue_entry_t head,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    gecko_fetch_queue_entry_t mem [DEPTH];
    logic                     do_push;
    logic                     do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/gecko_fetch_queue.sv
// Pairs fetch commands with in-order memory responses, drops redirect-stale work
// and drives one registered instruction slot to decode. GECKO_FETCH_QUEUE_STATS_EN
// enables the saturating drop_count statistic (tied to zero otherwise).
module gecko_fetch_queue
    import gecko_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          JUMP_FLAG_WIDTH = GECKO_JUMP_FLAG_WIDTH,
    parameter int unsigned START_FLAG      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_pc,
    input  logic [31:0]                cmd_next_pc,
    input  logic [JUMP_FLAG_WIDTH-1:0] cmd_jump_flag,
    input  logic                       cmd_pred_miss,
    input  logic [1:0]                 cmd_pred_history,
    input  logic                       rsp_valid,
    output logic                       rsp_ready,
    input  logic [31:0]                rsp_data,
    input  logic                       jump_valid,
    input  logic                       jump_update_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_next_pc,
    output logic [JUMP_FLAG_WIDTH-1:0] out_jump_flag,
    output logic                       out_pred_miss,
    output logic [1:0]                 out_pred_history,
    output logic [31:0]                out_instruction,
    output logic [31:0]                drop_count
);

    localparam gecko_jump_flag_t START_FLAG_V = gecko_jump_flag_t'(START_FLAG);

    gecko_fetch_queue_entry_t cmd_entry;
    gecko_fetch_queue_entry_t head;
    gecko_fetch_queue_entry_t out_q;
    logic [31:0]              out_instr_q;
    logic                     out_valid_q;
    gecko_jump_flag_t         expected_flag;
    gecko_jump_flag_t         flag_next;
    logic                     full;
    logic                     empty;
    logic                     redirect;
    logic                     head_stale;
    logic                     out_free;
    logic                     pair;
    logic                     pair_keep;
    logic                     out_flush;

    assign cmd_entry = '{
        pc:         cmd_pc,
        next_pc:    cmd_next_pc,
        jump_flag:  cmd_jump_flag,
        prediction: '{miss: cmd_pred_miss, history: cmd_pred_history}
    };

    gecko_fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid && cmd_ready),
        .wr_entry (cmd_entry),
        .pop      (pair),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // Staleness is judged against the post-redirect flag, so a redirect wins over
    // a pairing or an output hold in the same cycle.
    assign redirect   = jump_valid && jump_update_pc;
    assign flag_next  = expected_flag + gecko_jump_flag_t'(redirect);
    assign head_stale = !empty && (head.jump_flag != flag_next);
    assign out_free   = !out_valid_q || out_ready;
    assign cmd_ready  = !full;
    assign rsp_ready  = !empty && (head_stale || out_free);
    assign pair       = rsp_valid && rsp_ready;
    assign pair_keep  = pair && !head_stale;
    assign out_flush  = redirect && out_valid_q && (out_q.jump_flag != flag_next);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected_flag <= START_FLAG_V;
            out_valid_q   <= 1'b0;
            out_q         <= '0;
            out_instr_q   <= '0;
        end else begin
            expected_flag <= flag_next;
            if (pair_keep) begin
                out_valid_q <= 1'b1;
                out_q       <= head;
                out_instr_q <= rsp_data;
            end else if (out_flush || (out_valid_q && out_ready)) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid        = out_valid_q;
    assign out_pc           = out_q.pc;
    assign out_next_pc      = out_q.next_pc;
    assign out_jump_flag    = out_q.jump_flag;
    assign out_pred_miss    = out_q.prediction.miss;
    assign out_pred_history = out_q.prediction.history;
    assign out_instruction  = out_instr_q;

`ifdef GECKO_FETCH_QUEUE_STATS_EN
    logic        pair_drop;
    logic        flush_drop;
    logic [1:0]  drop_inc;
    logic [31:0] drop_q;

    // A flushed output that decode accepts in the same cycle was delivered, not dropped.
    assign pair_drop  = pair && head_stale;
    assign flush_drop = out_flush && !out_ready;
    assign drop_inc   = {1'b0, pair_drop} + {1'b0, flush_drop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= gecko_sat_add(drop_q, drop_inc);
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst) !(rsp_valid && empty));

endmodule

// File: tb/tb_gecko_fetch_queue.sv
// Directed bench for gecko_fetch_queue: a vector table for steady flow and
// backpressure, then hand sequences for full, redirect, wrap and reset.
module tb_gecko_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_pc = '0;
    logic [31:0] cmd_next_pc = '0;
    logic [1:0]  cmd_jump_flag = '0;
    logic        cmd_pred_miss = 1'b0;
    logic [1:0]  cmd_pred_history = '0;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_data = '0;
    logic        jump_valid = 1'b0;
    logic        jump_update_pc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic [1:0]  out_jump_flag;
    logic        out_pred_miss;
    logic [1:0]  out_pred_history;
    logic [31:0] out_instruction;
    logic [31:0] drop_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_drops = '0;

    gecko_fetch_queue #(
        .DEPTH           (4),
        .JUMP_FLAG_WIDTH (2),
        .START_FLAG      (0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_pc           (cmd_pc),
        .cmd_next_pc      (cmd_next_pc),
        .cmd_jump_flag    (cmd_jump_flag),
        .cmd_pred_miss    (cmd_pred_miss),
        .cmd_pred_history (cmd_pred_history),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .jump_valid       (jump_valid),
        .jump_update_pc   (jump_update_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_next_pc      (out_next_pc),
        .out_jump_flag    (out_jump_flag),
        .out_pred_miss    (out_pred_miss),
        .out_pred_history (out_pred_history),
        .out_instruction  (out_instruction),
        .drop_count       (drop_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_drop_count();
`ifdef GECKO_FETCH_QUEUE_STATS_EN
        return exp_drops;
`else
        return 32'd0;
`endif
    endfunction

    // Next pc and predictor fields are derived from pc so pass-through is checkable.
    task automatic check_out(input string name, input logic [31:0] pc, input logic [1:0] flag,
                             input logic [31:0] instr);
        check({name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, ".out_pc"}, out_pc, pc);
        check({name, ".out_next_pc"}, out_next_pc, pc + 32'd4);
        check({name, ".out_jump_flag"}, {30'd0, out_jump_flag}, {30'd0, flag});
        check({name, ".out_pred_miss"}, {31'd0, out_pred_miss}, {31'd0, pc[2]});
        check({name, ".out_pred_history"}, {30'd0, out_pred_history}, {30'd0, pc[3:2]});
        check({name, ".out_instruction"}, out_instruction, instr);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic cv, input logic [31:0] pc, input logic [1:0] flag,
                         input logic rv, input logic [31:0] data,
                         input logic jv, input logic jup, input logic ordy);
        @(negedge clk);
        cmd_valid        = cv;
        cmd_pc           = pc;
        cmd_next_pc      = pc + 32'd4;
        cmd_jump_flag    = flag;
        cmd_pred_miss    = pc[2];
        cmd_pred_history = pc[3:2];
        rsp_valid        = rv;
        rsp_data         = data;
        jump_valid       = jv;
        jump_update_pc   = jup;
        out_ready        = ordy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic        cv;
        logic [31:0] pc;
        logic        rv;
        logic [31:0] data;
        logic        ordy;
        logic        e_cmd_ready;
        logic        e_rsp_ready;
        logic        e_out_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [1:0] e_flag;
        logic [1:0] s_flag;

        // In-order flow (rows 0-5), then backpressure with two queued responses (6-15).
        vecs[0]  = '{1'b1, 32'h00, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[1]  = '{1'b1, 32'h04, 1'b1, 32'h13,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[2]  = '{1'b1, 32'h08, 1'b1, 32'h00100093,  1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 32'h13};
        vecs[3]  = '{1'b0, 32'h00, 1'b1, 32'h00200113,  1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 32'h00100093};
        vecs[4]  = '{1'b0, 32'h00, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h08, 32'h00200113};
        vecs[5]  = '{1'b0, 32'h00, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[6]  = '{1'b1, 32'h20, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[7]  = '{1'b1, 32'h24, 1'b1, 32'hAAAA0001,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[8]  = '{1'b1, 32'h28, 1'b1, 32'hAAAA0002,  1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'hAAAA0001};
        vecs[9]  = '{1'b0, 32'h00, 1'b1, 32'hAAAA0002,  1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'hAAAA0001};
        vecs[10] = '{1'b0, 32'h00, 1'b1, 32'hAAAA0002,  1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'hAAAA0001};
        vecs[11] = '{1'b0, 32'h00, 1'b1, 32'hAAAA0002,  1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'hAAAA0001};
        vecs[12] = '{1'b0, 32'h00, 1'b1, 32'hAAAA0002,  1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'hAAAA0001};
        vecs[13] = '{1'b0, 32'h00, 1'b1, 32'hAAAA0003,  1'b1, 1'b1, 1'b1, 1'b1, 32'h24, 32'hAAAA0002};
        vecs[14] = '{1'b0, 32'h00, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h28, 32'hAAAA0003};
        vecs[15] = '{1'b0, 32'h00, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_pc", out_pc, 32'd0);
        check("rst.out_next_pc", out_next_pc, 32'd0);
        check("rst.out_instruction", out_instruction, 32'd0);
        check("rst.out_jump_flag", {30'd0, out_jump_flag}, 32'd0);
        check("rst.rsp_ready", {31'd0, rsp_ready}, 32'd0);
        check("rst.drop_count", drop_count, 32'd0);
        rst = 1'b1;
        #1;
        check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // ---------------- table ----------------
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cv, vecs[i].pc, 2'd0, vecs[i].rv, vecs[i].data, 1'b0, 1'b0, vecs[i].ordy);
            check($sformatf("vec%0d.cmd_ready", i), {31'd0, cmd_ready}, {31'd0, vecs[i].e_cmd_ready});
            check($sformatf("vec%0d.rsp_ready", i), {31'd0, rsp_ready}, {31'd0, vecs[i].e_rsp_ready});
            check($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_out_valid});
            if (vecs[i].e_out_valid)
                check_out($sformatf("vec%0d", i), vecs[i].e_pc, 2'd0, vecs[i].e_instr);
        end

        // ---------------- full ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            check($sformatf("full.fill%0d.cmd_ready", i), {31'd0, cmd_ready}, 32'd1);
        end
        drive(1'b1, 32'h50, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("full.c5.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        drive(1'b1, 32'h50, 2'd0, 1'b1, 32'hD000_0000, 1'b0, 1'b0, 1'b1);
        check("full.pop.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("full.pop.rsp_ready", {31'd0, rsp_ready}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 32'd0, 2'd0, 1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
            check($sformatf("full.drain%0d.cmd_ready", i), {31'd0, cmd_ready}, 32'd1);
            check_out($sformatf("full.drain%0d", i), 32'h40 + 32'(4 * (i - 1)), 2'd0,
                      32'hD000_0000 + 32'(i - 1));
        end
        idle();
        check_out("full.last", 32'h4C, 2'd0, 32'hD000_0003);
        idle();
        check("full.end.out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- redirect flush ----------------
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h60 + 32'(4 * i), 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        check("flush.jump.rsp_ready", {31'd0, rsp_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(i == 2, 32'h100, 2'd1, 1'b1, 32'hEEEE_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
            check($sformatf("flush.drop%0d.rsp_ready", i), {31'd0, rsp_ready}, 32'd1);
            check($sformatf("flush.drop%0d.out_valid", i), {31'd0, out_valid}, 32'd0);
        end
        exp_drops = exp_drops + 32'd3;
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("flush.drop_count", drop_count, exp_drop_count());
        check("flush.idle.out_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 32'd0, 2'd0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1);
        check("flush.new.rsp_ready", {31'd0, rsp_ready}, 32'd1);
        idle();
        check_out("flush.new", 32'h100, 2'd1, 32'hCAFE_0001);
        idle();
        check("flush.end.out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- redirect vs held output ----------------
        drive(1'b1, 32'h200, 2'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 2'd0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check_out("held.pre", 32'h200, 2'd1, 32'h1234_5678);
        exp_drops = exp_drops + 32'd1;
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("held.post.out_valid", {31'd0, out_valid}, 32'd0);
        check("held.drop_count", drop_count, exp_drop_count());

        // ---------------- flag wrap ----------------
        // Flag is 2 here: two redirects bring it to 0, a jump without update_pc must not count.
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            e_flag = 2'(k + 1);
            s_flag = e_flag - 2'd1;
            drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
            check($sformatf("wrap%0d.jump.out_valid", k), {31'd0, out_valid}, 32'd0);
            drive(1'b1, 32'h300 + 32'(16 * k), s_flag, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            drive(1'b1, 32'h304 + 32'(16 * k), e_flag, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            drive(1'b0, 32'd0, 2'd0, 1'b1, 32'hBAD0_0000 + 32'(k), 1'b0, 1'b0, 1'b1);
            check($sformatf("wrap%0d.stale.rsp_ready", k), {31'd0, rsp_ready}, 32'd1);
            exp_drops = exp_drops + 32'd1;
            drive(1'b0, 32'd0, 2'd0, 1'b1, 32'h600D_0000 + 32'(k), 1'b0, 1'b0, 1'b1);
            check($sformatf("wrap%0d.good.rsp_ready", k), {31'd0, rsp_ready}, 32'd1);
            check($sformatf("wrap%0d.good.out_valid", k), {31'd0, out_valid}, 32'd0);
            idle();
            check_out($sformatf("wrap%0d", k), 32'h304 + 32'(16 * k), e_flag, 32'h600D_0000 + 32'(k));
        end
        idle();
        check("wrap.drop_count", drop_count, exp_drop_count());

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 32'h400, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h404, 2'd0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_out("mid.pre", 32'h400, 2'd0, 32'h11);
        rst = 1'b0;
        exp_drops = '0;
        #1;
        check("mid.out_valid", {31'd0, out_valid}, 32'd0);
        check("mid.out_pc", out_pc, 32'd0);
        check("mid.out_instruction", out_instruction, 32'd0);
        check("mid.rsp_ready", {31'd0, rsp_ready}, 32'd0);
        check("mid.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid.drop_count", drop_count, exp_drop_count());
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            check($sformatf("post.fill%0d.cmd_ready", i), {31'd0, cmd_ready}, 32'd1);
        end
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("post.full.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 2'd0, 1'b1, 32'h7000 + 32'(i), 1'b0, 1'b0, 1'b1);
            check($sformatf("post.rsp%0d.rsp_ready", i), {31'd0, rsp_ready}, 32'd1);
            if (i > 0)
                check_out($sformatf("post.out%0d", i), 32'h500 + 32'(4 * (i - 1)), 2'd0, 32'h7000 + 32'(i - 1));
        end
        idle();
        check_out("post.last", 32'h50C, 2'd0, 32'h7003);
        idle();
        check("post.end.out_valid", {31'd0, out_valid}, 32'd0);
        check("post.end.rsp_ready", {31'd0, rsp_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
